// File: rtl/ls_74194_pkg.sv
// Shared definitions for the ls_74194 universal shift register: the 2-bit mode select encoding.
package ls_74194_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : ls_74194_pkg

// File: rtl/ls_74194_cell.sv
// One bit of the universal shift register: 4:1 mux (hold, upper neighbour, lower neighbour, load bit)
// feeding a flop with synchronous clear.
module ls_74194_cell
    import ls_74194_pkg::*;
(
    input  logic  clk,
    input  logic  clear,
    input  mode_e mode_i,
    input  logic  hi_i,
    input  logic  lo_i,
    input  logic  p_i,
    output logic  q_o
);

    logic q_q;
    logic q_d;

    // Shift right pulls from the higher-order neighbour, shift left from the lower-order one.
    always_comb begin
        q_d = q_q;
        case (mode_i)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = hi_i;
            MODE_SHL:  q_d = lo_i;
            MODE_LOAD: q_d = p_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : ls_74194_cell

// File: rtl/ls_74194.sv
// 74x194-style synchronous universal shift register: hold, shift right, shift left, parallel load,
// with synchronous clear taking priority over the mode select.
module ls_74194
    import ls_74194_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] p,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q
);

    mode_e            mode;
    logic [WIDTH-1:0] hi_nb;
    logic [WIDTH-1:0] lo_nb;

    assign mode  = mode_e'(s);
    // The serial inputs act as the outer neighbours of the boundary cells.
    assign hi_nb = {sir, q[WIDTH-1:1]};
    assign lo_nb = {q[WIDTH-2:0], sil};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ls_74194_cell u_cell (
            .clk    (clk),
            .clear  (clear),
            .mode_i (mode),
            .hi_i   (hi_nb[i]),
            .lo_i   (lo_nb[i]),
            .p_i    (p[i]),
            .q_o    (q[i])
        );
    end

endmodule : ls_74194

// File: tb/tb_ls_74194.sv
// Directed self-checking bench for ls_74194 with hand-computed expected register contents.
module tb_ls_74194;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic [1:0]   s;
    logic [W-1:0] p;
    logic         sil;
    logic         sir;
    logic [W-1:0] q;

    int n_cmp = 0;
    int n_bad = 0;

    ls_74194 #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .s     (s),
        .p     (p),
        .sil   (sil),
        .sir   (sir),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs on the falling edge, then let one rising edge take effect.
    task automatic step(input logic clr, input logic [1:0] mode, input logic [W-1:0] pv,
                        input logic l, input logic r);
        @(negedge clk);
        clear = clr;
        s     = mode;
        p     = pv;
        sil   = l;
        sir   = r;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (clear === 1'b0 && $isunknown(s))
            check("s_xz", W'($isunknown(s)), '0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b1; s = 2'b00; p = '0; sil = 1'b0; sir = 1'b0;

        step(1'b1, 2'b00, 4'b1010, 1'b0, 1'b0); check("clr_hold", q, 4'b0000);
        step(1'b1, 2'b11, 4'b1010, 1'b1, 1'b1); check("clr_beats_load", q, 4'b0000);

        step(1'b0, 2'b11, 4'b1010, 1'b1, 1'b1); check("load", q, 4'b1010);

        step(1'b0, 2'b01, 4'b1111, 1'b1, 1'b0); check("shr_sir0", q, 4'b0101);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b1); check("shr_sir1", q, 4'b1010);

        step(1'b0, 2'b10, 4'b0000, 1'b1, 1'b1); check("shl_sil1", q, 4'b0101);
        step(1'b0, 2'b10, 4'b1111, 1'b0, 1'b1); check("shl_1", q, 4'b1010);
        step(1'b0, 2'b10, 4'b1111, 1'b0, 1'b1); check("shl_2", q, 4'b0100);
        step(1'b0, 2'b10, 4'b1111, 1'b0, 1'b1); check("shl_3", q, 4'b1000);
        step(1'b0, 2'b10, 4'b1111, 1'b0, 1'b1); check("shl_4", q, 4'b0000);

        step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0); check("load2", q, 4'b1010);
        step(1'b0, 2'b00, 4'b0101, 1'b1, 1'b0); check("hold_1", q, 4'b1010);
        step(1'b0, 2'b00, 4'b1111, 1'b0, 1'b1); check("hold_2", q, 4'b1010);
        step(1'b0, 2'b00, 4'b0000, 1'b1, 1'b1); check("hold_3", q, 4'b1010);

        step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0); check("load_ones", q, 4'b1111);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b1); check("shr_keep1", q, 4'b1111);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b1); check("shr_keep2", q, 4'b1111);
        step(1'b1, 2'b01, 4'b1111, 1'b1, 1'b1); check("clr_mid", q, 4'b0000);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b1); check("resume_shr", q, 4'b1000);

        step(1'b0, 2'b10, 4'b1111, 1'b1, 1'b0); check("shl_mixed", q, 4'b0001);
        step(1'b0, 2'b11, 4'b0110, 1'b1, 1'b1); check("load_mixed", q, 4'b0110);
        step(1'b0, 2'b01, 4'b1111, 1'b1, 1'b0); check("shr_mixed", q, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ls_74194
